// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin scheduler that shares one UART tx line, paced by baud_gen rising edges.
// Define UART_TX_PARITY_EN to append an even parity bit after the data bits.
module uart_tx_sched #(
    parameter int NREQ   = 4,
    parameter int DATA_W = 8
) (
    input  logic                     clock,
    input  logic                     rst,
    input  logic                     baud_in,
    input  logic [1:0]               cfg_baud,
    output logic [1:0]               baud_sel,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*DATA_W-1:0]   din,
    output logic [NREQ-1:0]          gnt,
    output logic [$clog2(NREQ)-1:0]  owner,
    output logic                     busy,
    output logic                     done,
    output logic                     tx
);
    localparam int OW = $clog2(NREQ);
    localparam int BW = $clog2(DATA_W);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] WAIT   = 3'd1;
    localparam logic [2:0] START  = 3'd2;
    localparam logic [2:0] DATA   = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] PARITY = 3'd5;
`endif

    logic [2:0]        state;
    logic              baud_d;
    logic              bedge;
    logic [OW-1:0]     last;
    logic [DATA_W-1:0] shreg;
    logic [BW-1:0]     bitcnt;
`ifdef UART_TX_PARITY_EN
    logic              par;
`endif

    logic              any_req;
    logic [OW-1:0]     winner;
    logic [NREQ-1:0]   sel_gnt;
    logic [DATA_W-1:0] sel_data;

    assign bedge = baud_in & ~baud_d;
    assign busy  = (state != IDLE);

    // Search priority distance k = 1..NREQ from the last winner; the nearest set request wins.
    always_comb begin
        any_req  = 1'b0;
        winner   = '0;
        sel_gnt  = '0;
        sel_data = '0;
        for (int k = 1; k <= NREQ; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!any_req && req[i] && (((int'(last) + k) % NREQ) == i)) begin
                    any_req    = 1'b1;
                    winner     = OW'(i);
                    sel_gnt[i] = 1'b1;
                    sel_data   = din[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            baud_d   <= 1'b0;
            state    <= IDLE;
            last     <= OW'(NREQ-1);
            shreg    <= '0;
            bitcnt   <= '0;
            tx       <= 1'b1;
            gnt      <= '0;
            done     <= 1'b0;
            owner    <= '0;
            baud_sel <= 2'b00;
`ifdef UART_TX_PARITY_EN
            par      <= 1'b0;
`endif
        end else begin
            baud_d <= baud_in;
            gnt    <= '0;
            done   <= 1'b0;
            case (state)
                IDLE: begin
                    // Rate changes are only allowed here so a frame never straddles two rates.
                    baud_sel <= cfg_baud;
                    if (any_req) begin
                        gnt   <= sel_gnt;
                        owner <= winner;
                        last  <= winner;
                        shreg <= sel_data;
`ifdef UART_TX_PARITY_EN
                        par   <= ^sel_data;
`endif
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (bedge) begin
                        tx    <= 1'b0;
                        state <= START;
                    end
                end
                START: begin
                    if (bedge) begin
                        tx     <= shreg[0];
                        shreg  <= shreg >> 1;
                        bitcnt <= '0;
                        state  <= DATA;
                    end
                end
                DATA: begin
                    if (bedge) begin
                        if (bitcnt == BW'(DATA_W-1)) begin
`ifdef UART_TX_PARITY_EN
                            tx    <= par;
                            state <= PARITY;
`else
                            tx    <= 1'b1;
                            state <= STOP;
`endif
                        end else begin
                            tx     <= shreg[0];
                            shreg  <= shreg >> 1;
                            bitcnt <= bitcnt + 1'b1;
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bedge) begin
                        tx    <= 1'b1;
                        state <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (bedge) begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
